// File: rtl/bias_add_pipe_n.sv
// N-lane signed vector bias adder: per-lane bias register file feeding a 2-stage valid/ready pipe.
// Optional feature macro: BIAS_ADD_PIPE_N_SAT_EN (clamp on narrowing, adds sat_o port).
module bias_add_pipe_n #(
    parameter int unsigned N            = 8,
    parameter int unsigned in_width_p   = 32,
    parameter int unsigned bias_width_p = 32,
    parameter int unsigned out_width_p  = 32,
    localparam int unsigned LaneW       = (N > 1) ? $clog2(N) : 1
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic                                bias_valid_i,
    output logic                                bias_ready_o,
    input  logic [LaneW-1:0]                    bias_lane_i,
    input  logic [bias_width_p-1:0]             bias_i,
    input  logic                                data_valid_i,
    output logic                                data_ready_o,
    input  logic [N-1:0][in_width_p-1:0]        data_i,
    output logic                                data_valid_o,
    input  logic                                data_ready_i,
`ifdef BIAS_ADD_PIPE_N_SAT_EN
    output logic [N-1:0]                        sat_o,
`endif
    output logic [N-1:0][out_width_p-1:0]       data_o
);

    localparam int unsigned SumW =
        ((in_width_p > bias_width_p) ? in_width_p : bias_width_p) + 1;

    logic [N-1:0][bias_width_p-1:0] bias_q;
    logic                           s1_v_q;
    logic                           s2_v_q;
    logic [N-1:0][SumW-1:0]         s1_sum_q;
    logic [N-1:0][SumW-1:0]         s1_sum_d;
    logic [N-1:0][out_width_p-1:0]  nar;
`ifdef BIAS_ADD_PIPE_N_SAT_EN
    logic [N-1:0]                   nar_sat;
`endif
    logic                           s1_rdy;
    logic                           s2_rdy;
    logic                           in_fire;

    assign s2_rdy       = ~s2_v_q | data_ready_i;
    assign s1_rdy       = ~s1_v_q | s2_rdy;
    assign data_ready_o = s1_rdy;
    assign in_fire      = data_valid_i & s1_rdy;
    assign data_valid_o = s2_v_q;

    // Writes to lanes >= N are silently dropped.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bias_ready_o <= 1'b0;
            bias_q       <= '0;
        end else begin
            bias_ready_o <= 1'b1;
            if (bias_valid_i && bias_ready_o && (32'(bias_lane_i) < N)) begin
                bias_q[bias_lane_i] <= bias_i;
            end
        end
    end

    // Reads bias_q before any same-edge write lands, so that beat sees the old bias.
    always_comb begin
        s1_sum_d = '0;
        for (int i = 0; i < int'(N); i++) begin
            s1_sum_d[i] = SumW'($signed(data_i[i])) + SumW'($signed(bias_q[i]));
        end
    end

    for (genvar i = 0; i < int'(N); i++) begin : g_lane
        logic signed [SumW-1:0] s;
        assign s = s1_sum_q[i];
        if (out_width_p >= SumW) begin : g_wide
            assign nar[i] = out_width_p'(s);
`ifdef BIAS_ADD_PIPE_N_SAT_EN
            assign nar_sat[i] = 1'b0;
`endif
        end else begin : g_narrow
`ifdef BIAS_ADD_PIPE_N_SAT_EN
            localparam logic [out_width_p-1:0] OutMin = out_width_p'(1) << (out_width_p - 1);
            logic ovf;
            // Overflow iff the bits dropped plus the new sign bit are not all equal.
            assign ovf        = ~((&s[SumW-1:out_width_p-1]) | ~(|s[SumW-1:out_width_p-1]));
            assign nar[i]     = ovf ? (s[SumW-1] ? OutMin : ~OutMin) : s[out_width_p-1:0];
            assign nar_sat[i] = ovf;
`else
            assign nar[i] = s[out_width_p-1:0];
`endif
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_v_q   <= 1'b0;
            s2_v_q   <= 1'b0;
            s1_sum_q <= '0;
            data_o   <= '0;
`ifdef BIAS_ADD_PIPE_N_SAT_EN
            sat_o    <= '0;
`endif
        end else begin
            if (s1_rdy) begin
                s1_v_q <= data_valid_i;
            end
            if (in_fire) begin
                s1_sum_q <= s1_sum_d;
            end
            if (s2_rdy) begin
                s2_v_q <= s1_v_q;
                if (s1_v_q) begin
                    data_o <= nar;
`ifdef BIAS_ADD_PIPE_N_SAT_EN
                    sat_o  <= nar_sat;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_bias_add_pipe_n.sv
// Directed bench for bias_add_pipe_n: a 4-lane 32/32/32 instance and a 6-lane 8/8/8 instance.
module tb_bias_add_pipe_n;

    logic clk;
    logic rst_ni;

    // Instance A: N=4, 32/32/32
    logic                 a_bias_valid_i, a_bias_ready_o;
    logic [1:0]           a_bias_lane_i;
    logic [31:0]          a_bias_i;
    logic                 a_data_valid_i, a_data_ready_o, a_data_valid_o, a_data_ready_i;
    logic [3:0][31:0]     a_data_i, a_data_o;

    // Instance B: N=6, 8/8/8 (sum is 9 bits, so output narrows)
    logic                 b_bias_valid_i, b_bias_ready_o;
    logic [2:0]           b_bias_lane_i;
    logic [7:0]           b_bias_i;
    logic                 b_data_valid_i, b_data_ready_o, b_data_valid_o, b_data_ready_i;
    logic [5:0][7:0]      b_data_i, b_data_o;
`ifdef BIAS_ADD_PIPE_N_SAT_EN
    logic [3:0]           a_sat;
    logic [5:0]           b_sat;
`endif

    int checks = 0;
    int errors = 0;

    bias_add_pipe_n #(
        .N(4), .in_width_p(32), .bias_width_p(32), .out_width_p(32)
    ) dut_a (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .bias_valid_i (a_bias_valid_i),
        .bias_ready_o (a_bias_ready_o),
        .bias_lane_i  (a_bias_lane_i),
        .bias_i       (a_bias_i),
        .data_valid_i (a_data_valid_i),
        .data_ready_o (a_data_ready_o),
        .data_i       (a_data_i),
        .data_valid_o (a_data_valid_o),
        .data_ready_i (a_data_ready_i),
`ifdef BIAS_ADD_PIPE_N_SAT_EN
        .sat_o        (a_sat),
`endif
        .data_o       (a_data_o)
    );

    bias_add_pipe_n #(
        .N(6), .in_width_p(8), .bias_width_p(8), .out_width_p(8)
    ) dut_b (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .bias_valid_i (b_bias_valid_i),
        .bias_ready_o (b_bias_ready_o),
        .bias_lane_i  (b_bias_lane_i),
        .bias_i       (b_bias_i),
        .data_valid_i (b_data_valid_i),
        .data_ready_o (b_data_ready_o),
        .data_i       (b_data_i),
        .data_valid_o (b_data_valid_o),
        .data_ready_i (b_data_ready_i),
`ifdef BIAS_ADD_PIPE_N_SAT_EN
        .sat_o        (b_sat),
`endif
        .data_o       (b_data_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout observed=running required=finished");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [3:0][31:0] ea;
        logic [5:0][7:0]  eb;
        int               bm [4];
        int               sent;
        int               rcvd;

        rst_ni         = 1'b1;
        a_bias_valid_i = 1'b0; a_bias_lane_i = '0; a_bias_i = '0;
        a_data_valid_i = 1'b0; a_data_i = '0; a_data_ready_i = 1'b1;
        b_bias_valid_i = 1'b0; b_bias_lane_i = '0; b_bias_i = '0;
        b_data_valid_i = 1'b0; b_data_i = '0; b_data_ready_i = 1'b1;
        #1 rst_ni = 1'b0;

        // T1: reset held with valids toggling
        for (int c = 0; c < 3; c++) begin
            a_data_valid_i = c[0]; a_bias_valid_i = ~c[0];
            b_data_valid_i = ~c[0]; b_bias_valid_i = c[0];
            step();
        end
        check("t1_a_valid_o", a_data_valid_o, 1'b0);
        check("t1_a_bias_rdy", a_bias_ready_o, 1'b0);
        check("t1_b_valid_o", b_data_valid_o, 1'b0);
        check("t1_b_bias_rdy", b_bias_ready_o, 1'b0);
        check("t1_a_data_o", a_data_o, '0);
        a_data_valid_i = 1'b0; a_bias_valid_i = 1'b0;
        b_data_valid_i = 1'b0; b_bias_valid_i = 1'b0;
        rst_ni = 1'b1;
        #1;
        check("t1_bias_rdy_before_edge", a_bias_ready_o, 1'b0);
        step();
        check("t1_a_bias_rdy_after", a_bias_ready_o, 1'b1);
        check("t1_b_bias_rdy_after", b_bias_ready_o, 1'b1);

        // T2: bias {1,-2,3,-4}, data {10,10,-10,0}
        bm[0] = 1; bm[1] = -2; bm[2] = 3; bm[3] = -4;
        a_bias_valid_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a_bias_lane_i = 2'(i);
            a_bias_i      = 32'(bm[i]);
            step();
        end
        a_bias_valid_i = 1'b0;
        a_data_i[0] = 32'sd10; a_data_i[1] = 32'sd10; a_data_i[2] = -32'sd10; a_data_i[3] = 32'sd0;
        a_data_valid_i = 1'b1;
        step();
        a_data_valid_i = 1'b0;
        check("t2_valid_after_1", a_data_valid_o, 1'b0);
        step();
        check("t2_valid_after_2", a_data_valid_o, 1'b1);
        ea[0] = 32'sd11; ea[1] = 32'sd8; ea[2] = -32'sd7; ea[3] = -32'sd4;
        check("t2_data", a_data_o, ea);

        // T3: bias[0]=5 written on the same edge beat A is accepted
        a_data_i = '0;
        a_data_valid_i = 1'b1;
        a_bias_valid_i = 1'b1; a_bias_lane_i = 2'd0; a_bias_i = 32'sd5;
        step();
        a_bias_valid_i = 1'b0;
        step();
        a_data_valid_i = 1'b0;
        check("t3_a_valid", a_data_valid_o, 1'b1);
        check("t3_a_lane0_old", a_data_o[0], 32'sd1);
        step();
        check("t3_b_valid", a_data_valid_o, 1'b1);
        check("t3_b_lane0_new", a_data_o[0], 32'sd5);
        step();
        check("t3_drained", a_data_valid_o, 1'b0);
        bm[0] = 5;

        // T4: 6 beats with a 4-cycle downstream stall
        sent = 0;
        rcvd = 0;
        for (int c = 0; c < 20; c++) begin
            a_data_ready_i = (c < 2) || (c >= 6);
            a_data_valid_i = (sent < 6);
            for (int i = 0; i < 4; i++) a_data_i[i] = 32'(100 * sent + i);
            #1;
            if (c == 3) check("t4_ready_low", a_data_ready_o, 1'b0);
            if (c == 4) check("t4_valid_held", a_data_valid_o, 1'b1);
            if (a_data_valid_o && a_data_ready_i) begin
                for (int i = 0; i < 4; i++) ea[i] = 32'(100 * rcvd + i + bm[i]);
                check("t4_beat", a_data_o, ea);
                rcvd++;
            end
            if (a_data_valid_i && a_data_ready_o) sent++;
            step();
        end
        a_data_valid_i = 1'b0;
        a_data_ready_i = 1'b1;
        check("t4_sent", 128'(sent), 128'(6));
        check("t4_rcvd", 128'(rcvd), 128'(6));

        // T5/T6: instance B biases, then writes to illegal lanes 6 and 7
        b_bias_valid_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            b_bias_lane_i = 3'(i);
            case (i)
                0: b_bias_i = 8'sd10;
                1: b_bias_i = -8'sd10;
                2: b_bias_i = 8'sd3;
                6, 7: b_bias_i = 8'h55;
                default: b_bias_i = 8'sd0;
            endcase
            step();
        end
        b_bias_valid_i = 1'b0;
        b_data_i[0] = 8'sd120; b_data_i[1] = -8'sd120; b_data_i[2] = 8'sd5;
        b_data_i[3] = 8'sd1;   b_data_i[4] = 8'sd1;    b_data_i[5] = 8'sd1;
        b_data_valid_i = 1'b1;
        step();
        b_data_valid_i = 1'b0;
        step();
        check("t5_valid", b_data_valid_o, 1'b1);
`ifdef BIAS_ADD_PIPE_N_SAT_EN
        eb[0] = 8'h7F; eb[1] = 8'h80;
        check("t5_sat", b_sat, 6'b000011);
        check("t5_a_sat", a_sat, 4'b0000);
`else
        eb[0] = 8'h82; eb[1] = 8'h7E;
`endif
        eb[2] = 8'd8; eb[3] = 8'd1; eb[4] = 8'd1; eb[5] = 8'd1;
        check("t5_t6_data", b_data_o, eb);
        step();

        // T6: reset with two beats in flight
        b_data_i = '0;
        b_data_valid_i = 1'b1;
        step();
        step();
        b_data_valid_i = 1'b0;
        rst_ni = 1'b0;
        #1;
        check("t6_rst_b_valid", b_data_valid_o, 1'b0);
        check("t6_rst_b_data", b_data_o, '0);
        step();
        rst_ni = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            check("t6_no_output", b_data_valid_o, 1'b0);
        end
        check("t6_bias_rdy", b_bias_ready_o, 1'b1);
        for (int i = 0; i < 6; i++) b_data_i[i] = 8'sd7;
        b_data_valid_i = 1'b1;
        step();
        b_data_valid_i = 1'b0;
        step();
        check("t6_cleared_valid", b_data_valid_o, 1'b1);
        for (int i = 0; i < 6; i++) eb[i] = 8'sd7;
        check("t6_bias_cleared", b_data_o, eb);
        check("t6_a_idle", a_data_valid_o, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
